// File: rtl/hazard_pkg.sv
// Shared constants and types for the LEGv8 pipeline hazard controller.
// Scoreboard counts encode how far a pending register write is from write-back.
package hazard_pkg;
  localparam logic [4:0] XZR = 5'd31;

  typedef logic [1:0] sb_cnt_t;

  localparam sb_cnt_t SB_EX  = 2'd3;
  localparam sb_cnt_t SB_MEM = 2'd2;
  localparam sb_cnt_t SB_WB  = 2'd1;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// The count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  // Count enabled cycles, stopping at the maximum value.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard detection and taken-branch flush control for a 5-stage LEGv8 pipeline
// without forwarding; a per-register scoreboard tracks in-flight writes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_D,
  input  logic [4:0]       rm_D,
  input  logic             use_rn_D,
  input  logic             use_rm_D,
  input  logic [4:0]       rd_D,
  input  logic             regWrite_D,
  input  logic             valid_D,
  input  logic             branch_taken_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             bubble_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  sb_cnt_t r_sb     [NREG];
  sb_cnt_t w_sb_nxt [NREG];

  logic w_rn_hit;
  logic w_rm_hit;
  logic w_hazard;
  logic w_issue;
  logic w_stall;
  logic w_flush;

  // A producer in WB is harmless because the register file writes before it reads.
  assign w_rn_hit = use_rn_D && (rn_D != XZR) && (r_sb[rn_D] >= SB_MEM);
  assign w_rm_hit = use_rm_D && (rm_D != XZR) && (r_sb[rm_D] >= SB_MEM);
  assign w_hazard = valid_D && (w_rn_hit || w_rm_hit);
  assign w_issue  = valid_D && !w_hazard && !branch_taken_M;

  // Control outputs; a flush overrides a stall and everything is quiet in reset.
  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    if (reset) begin
      w_stall = w_hazard && !branch_taken_M;
      w_flush = branch_taken_M;
    end else begin
      w_stall = 1'b0;
      w_flush = 1'b0;
    end
  end

  assign stall_F  = w_stall;
  assign stall_D  = w_stall;
  assign bubble_E = w_stall;
  assign flush_D  = w_flush;
  assign flush_E  = w_flush;
  assign flush_M  = w_flush;

  // Age every pending write by one stage; squash EX on a taken branch; newest issue wins.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_sb_nxt[i] = r_sb[i];
      if (branch_taken_M && (r_sb[i] == SB_EX)) begin
        w_sb_nxt[i] = 2'd0;
      end else if (r_sb[i] != 2'd0) begin
        w_sb_nxt[i] = r_sb[i] - SB_WB;
      end else begin
        w_sb_nxt[i] = r_sb[i];
      end
      if (w_issue && regWrite_D && (rd_D != XZR) && (rd_D == 5'(i))) begin
        w_sb_nxt[i] = SB_EX;
      end else begin
        w_sb_nxt[i] = w_sb_nxt[i];
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!reset) begin
        r_sb[i] <= 2'd0;
      end else begin
        r_sb[i] <= w_sb_nxt[i];
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_clr_n (reset),
    .i_en    (w_stall),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (clk),
    .i_clr_n (reset),
    .i_en    (w_flush),
    .o_count (flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: a pipeline-occupancy model (which destination sits in EX/MEM)
// predicts every control output and counter each cycle, plus directed literal checks.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rn_D = 5'd0, rm_D = 5'd0, rd_D = 5'd0;
  logic        use_rn_D = 1'b0, use_rm_D = 1'b0, regWrite_D = 1'b0;
  logic        valid_D = 1'b0, branch_taken_M = 1'b0;
  logic        stall_F, stall_D, bubble_E, flush_D, flush_E, flush_M;
  logic [31:0] stall_cnt, flush_cnt;

  logic        sat_clr_n = 1'b0, sat_en = 1'b0;
  logic [1:0]  sat_q;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: destination register in EX and MEM (-1 = none), expected counters.
  int m_ex = -1;
  int m_mem = -1;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  bit started = 1'b0;

  hazard_ctrl #(.NREG(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rn_D(rn_D), .rm_D(rm_D),
    .use_rn_D(use_rn_D), .use_rm_D(use_rm_D), .rd_D(rd_D),
    .regWrite_D(regWrite_D), .valid_D(valid_D), .branch_taken_M(branch_taken_M),
    .stall_F(stall_F), .stall_D(stall_D), .bubble_E(bubble_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  sat_counter #(.W(2)) u_sat (
    .i_clk(clk), .i_clr_n(sat_clr_n), .i_en(sat_en), .o_count(sat_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_flight(input logic [4:0] r);
    return (r != 5'd31) && ((int'(r) == m_ex) || (int'(r) == m_mem));
  endfunction

  function automatic bit m_hazard();
    return valid_D && ((use_rn_D && in_flight(rn_D)) || (use_rm_D && in_flight(rm_D)));
  endfunction

  // Model advance: instructions move one stage per clock, a taken branch kills EX.
  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      m_ex <= -1;
      m_mem <= -1;
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
    end else begin
      m_mem <= branch_taken_M ? -1 : m_ex;
      if (valid_D && !m_hazard() && !branch_taken_M && regWrite_D && rd_D != 5'd31)
        m_ex <= int'(rd_D);
      else
        m_ex <= -1;
      if (m_hazard() && !branch_taken_M) m_stall_cnt <= m_stall_cnt + 1;
      if (branch_taken_M) m_flush_cnt <= m_flush_cnt + 1;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      logic exp_st, exp_fl;
      exp_st = reset && m_hazard() && !branch_taken_M;
      exp_fl = reset && branch_taken_M;
      chk("m_stall_F", 32'(stall_F), 32'(exp_st));
      chk("m_stall_D", 32'(stall_D), 32'(exp_st));
      chk("m_bubble_E", 32'(bubble_E), 32'(exp_st));
      chk("m_flush_D", 32'(flush_D), 32'(exp_fl));
      chk("m_flush_E", 32'(flush_E), 32'(exp_fl));
      chk("m_flush_M", 32'(flush_M), 32'(exp_fl));
      chk("m_stall_cnt", stall_cnt, 32'(m_stall_cnt));
      chk("m_flush_cnt", flush_cnt, 32'(m_flush_cnt));
    end
  end

  // One ID-stage cycle with literal expectations for stall and flush.
  task automatic cyc(input logic rst, input logic v, input logic [4:0] rn, input logic urn,
                     input logic [4:0] rm, input logic urm, input logic [4:0] rd,
                     input logic rw, input logic br, input logic exp_st,
                     input logic exp_fl, input string nm);
    reset = rst; valid_D = v; rn_D = rn; use_rn_D = urn; rm_D = rm; use_rm_D = urm;
    rd_D = rd; regWrite_D = rw; branch_taken_M = br;
    @(negedge clk);
    chk({nm, "_stall"}, 32'(stall_F), 32'(exp_st));
    chk({nm, "_flush"}, 32'(flush_D), 32'(exp_fl));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, "rst0");
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    idle(1);

    // ADD X1,X2,X3 then SUB X4,X1,X5: two stalls, issue on the third cycle
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, "t1_add");
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, "t1_sub_a");
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, "t1_sub_b");
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t1_sub_c");
    chk("t1_stall_cnt", stall_cnt, 32'd2);
    idle(3);

    // producer, independent, consumer: one stall
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, "t2_prod");
    cyc(1'b1, 1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, "t2_indep");
    cyc(1'b1, 1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, "t2_cons_a");
    cyc(1'b1, 1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, "t2_cons_b");
    chk("t2_stall_cnt", stall_cnt, 32'd3);
    idle(3);

    // writes to XZR never create a hazard
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, "t3_wzr");
    cyc(1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, "t3_rzr_a");
    cyc(1'b1, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, "t3_rzr_b");
    chk("t3_stall_cnt", stall_cnt, 32'd3);
    idle(3);

    // taken branch together with a hazard: flush wins, EX entry is squashed
    cyc(1'b1, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, "t4_prod");
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, "t4_br");
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, "t4_after");
    chk("t4_flush_cnt", flush_cnt, 32'd1);
    chk("t4_stall_cnt", stall_cnt, 32'd3);
    idle(3);

    // WAW on X7: reader waits two cycles behind the second writer
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, "t5_w1");
    cyc(1'b1, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, "t5_w2");
    cyc(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, "t5_rd_a");
    cyc(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, "t5_rd_b");
    cyc(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, "t5_rd_c");
    chk("t5_stall_cnt", stall_cnt, 32'd5);
    idle(3);

    // reset mid-stall clears scoreboard and counters
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_prod");
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, "t6_stall");
    cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, "t6_rst");
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, "t6_go");
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    chk("t6_flush_cnt", flush_cnt, 32'd0);
    idle(2);

    // saturation of a narrow counter: 0,1,2,3,3,3
    sat_clr_n = 1'b0; sat_en = 1'b0;
    @(posedge clk); #1;
    sat_clr_n = 1'b1; sat_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("sat_q", 32'(sat_q), (k < 3) ? 32'(k) : 32'd3);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
